// File: rtl/stopwatch_lap.sv
// stopwatch_lap: up/down stopwatch with a lap snapshot buffer.
//
// The stopwatch counts hh:mm:ss.cc. A tick is made by dividing clk down to TICK_HZ. It counts up
// from zero, or down from a loaded min:sec preset. It keeps up to LAP_DEPTH lap snapshots, which
// the display mux reads back by index. Button inputs are single-cycle pulses.
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   i_clear             clear pulse (STOP/DONE): zeros time, divider and lap buffer
//   i_runstop           run/stop toggle pulse
//   i_lap               lap capture pulse (RUN only)
//   i_mode              0 = count up, 1 = countdown; latched while in STOP
//   i_load              load {0, preset_min, preset_sec, 0} (STOP only)
//   i_preset_min/sec    countdown preset, each clamped to 59
//   i_lap_idx           lap read index
//   msec/sec/min/hour   current time fields
//   s_state             00 STOP, 01 RUN, 10 CLEAR, 11 DONE
//   o_lap_data          {hour,min,sec,msec} of entry i_lap_idx, 0 if not yet captured
//   o_lap_count         number of valid lap entries
//   o_lap_full          lap buffer full
//   o_done              countdown reached zero
module stopwatch_lap #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned LAP_DEPTH = 4,
  parameter int unsigned HOUR_MAX  = 24,
  localparam int unsigned IdxW     = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1,
  localparam int unsigned CntW     = $clog2(LAP_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_runstop,
  input  logic            i_lap,
  input  logic            i_mode,
  input  logic            i_load,
  input  logic [5:0]      i_preset_min,
  input  logic [5:0]      i_preset_sec,
  input  logic [IdxW-1:0] i_lap_idx,
  output logic [6:0]      msec,
  output logic [5:0]      sec,
  output logic [5:0]      min,
  output logic [4:0]      hour,
  output logic [1:0]      s_state,
  output logic [23:0]     o_lap_data,
  output logic [CntW-1:0] o_lap_count,
  output logic            o_lap_full,
  output logic            o_done
);

  localparam int unsigned DivMax = CLK_FREQ / TICK_HZ - 1;
  localparam int unsigned DivW   = (DivMax > 0) ? $clog2(DivMax + 1) : 1;
  localparam logic [DivW-1:0] DivTc   = DivW'(DivMax);
  localparam logic [6:0]      MsecTop = 7'(TICK_HZ - 1);
  localparam logic [4:0]      HourTop = 5'(HOUR_MAX - 1);
  localparam logic [CntW-1:0] LapCap  = CntW'(LAP_DEPTH);

  typedef enum logic [1:0] {
    StStop  = 2'b00,
    StRun   = 2'b01,
    StClear = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e          state_q;
  logic [6:0]      msec_q;
  logic [5:0]      sec_q, min_q;
  logic [4:0]      hour_q;
  logic [DivW-1:0] div_q;
  logic            mode_q;
  logic [CntW-1:0] lap_cnt_q;
  logic [23:0]     lap_q [LAP_DEPTH];

  // Next time value for each direction, used only on a tick.
  logic [6:0] up_msec, dn_msec;
  logic [5:0] up_sec, dn_sec, up_min, dn_min;
  logic [4:0] up_hour, dn_hour;
  logic       dn_zero, time_zero, lap_full, clr_now;
  logic [5:0] pre_min, pre_sec;

  always_comb begin
    up_msec = msec_q + 7'd1;
    up_sec  = sec_q;
    up_min  = min_q;
    up_hour = hour_q;
    if (msec_q == MsecTop) begin
      up_msec = '0;
      if (sec_q == 6'd59) begin
        up_sec = '0;
        if (min_q == 6'd59) begin
          up_min  = '0;
          up_hour = (hour_q == HourTop) ? 5'd0 : hour_q + 5'd1;
        end else begin
          up_min = min_q + 6'd1;
        end
      end else begin
        up_sec = sec_q + 6'd1;
      end
    end

    dn_msec = msec_q - 7'd1;
    dn_sec  = sec_q;
    dn_min  = min_q;
    dn_hour = hour_q;
    if (msec_q == 7'd0) begin
      dn_msec = MsecTop;
      if (sec_q == 6'd0) begin
        dn_sec = 6'd59;
        if (min_q == 6'd0) begin
          dn_min  = 6'd59;
          dn_hour = (hour_q == 5'd0) ? HourTop : hour_q - 5'd1;
        end else begin
          dn_min = min_q - 6'd1;
        end
      end else begin
        dn_sec = sec_q - 6'd1;
      end
    end
  end

  assign dn_zero   = (dn_msec == '0) && (dn_sec == '0) && (dn_min == '0) && (dn_hour == '0);
  assign time_zero = (msec_q == '0) && (sec_q == '0) && (min_q == '0) && (hour_q == '0);
  assign lap_full  = (lap_cnt_q == LapCap);
  assign clr_now   = i_clear && ((state_q == StStop) || (state_q == StDone));
  assign pre_min   = (i_preset_min > 6'd59) ? 6'd59 : i_preset_min;
  assign pre_sec   = (i_preset_sec > 6'd59) ? 6'd59 : i_preset_sec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StStop;
      msec_q    <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      div_q     <= '0;
      mode_q    <= 1'b0;
      lap_cnt_q <= '0;
      lap_q     <= '{default: '0};
    end else begin
      unique case (state_q)
        StStop: begin
          mode_q <= i_mode;
          if (i_load) begin
            msec_q <= '0;
            sec_q  <= pre_sec;
            min_q  <= pre_min;
            hour_q <= '0;
          end else if (i_runstop && !(i_mode && time_zero)) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (i_runstop) state_q <= StStop;
          if (div_q == DivTc) begin
            div_q <= '0;
            if (mode_q) begin
              msec_q <= dn_msec;
              sec_q  <= dn_sec;
              min_q  <= dn_min;
              hour_q <= dn_hour;
              // Reaching zero wins over a same-cycle stop so the finish is never lost.
              if (dn_zero) state_q <= StDone;
            end else begin
              msec_q <= up_msec;
              sec_q  <= up_sec;
              min_q  <= up_min;
              hour_q <= up_hour;
            end
          end else begin
            div_q <= div_q + DivW'(1);
          end
          // Snapshot is the registered (pre-tick) time.
          if (i_lap && !lap_full) begin
            lap_q[lap_cnt_q[IdxW-1:0]] <= {hour_q, min_q, sec_q, msec_q};
            lap_cnt_q                  <= lap_cnt_q + CntW'(1);
          end
        end
        StClear: state_q <= StStop;
        StDone: begin
          if (i_runstop) state_q <= StStop;
        end
      endcase

      // Clear overrides load/runstop; zero everything on entry to CLEAR.
      if (clr_now) begin
        state_q   <= StClear;
        msec_q    <= '0;
        sec_q     <= '0;
        min_q     <= '0;
        hour_q    <= '0;
        div_q     <= '0;
        lap_cnt_q <= '0;
        lap_q     <= '{default: '0};
      end
    end
  end

  always_comb begin
    o_lap_data = '0;
    if (CntW'(i_lap_idx) < lap_cnt_q) o_lap_data = lap_q[i_lap_idx];
  end

  assign msec        = msec_q;
  assign sec         = sec_q;
  assign min         = min_q;
  assign hour        = hour_q;
  assign s_state     = state_q;
  assign o_lap_count = lap_cnt_q;
  assign o_lap_full  = lap_full;
  assign o_done      = (state_q == StDone);

endmodule
